// File: rtl/neopixel_rx.sv
// WS2812 single-wire receiver: recovers 24-bit pixel words from the
// pulse-width-coded line, flags malformed pulses and reports frame ends
// (a long low latch gap) with the pixel count of the frame just finished.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// WAIT_GAP | not locked; waiting for a full latch gap before decoding
// IDLE     | locked, between frames; waiting for the first rising edge
// HIGH     | measuring a high pulse
// LOW      | measuring the low after a bit; a full gap ends the frame
module neopixel_rx #(
    parameter int ThreshCycles  = 12,
    parameter int MinHighCycles = 3,
    parameter int MaxHighCycles = 40,
    parameter int ResetCycles   = 1000,
    parameter int CntWidth      = 16
) (
    input  logic                soc_clk,
    input  logic                rst_n,
    input  logic                data_i,
    output logic [23:0]         pixel_o,
    output logic                pixel_valid_o,
    input  logic                pixel_ready_i,
    output logic                frame_done_o,
    output logic [CntWidth-1:0] frame_pixels_o,
    output logic                err_o,
    output logic                overflow_o,
    input  logic                err_clear_i
);

    localparam logic [1:0] ST_WAIT_GAP = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_HIGH     = 2'd2;
    localparam logic [1:0] ST_LOW      = 2'd3;

    // While a level is held, the cycles spent at that level so far equal
    // cnt + 2 (one cycle for the edge itself, one for the clear).
    localparam logic [CntWidth-1:0] GAP_LAST  = CntWidth'(ResetCycles - 2);
    localparam logic [CntWidth-1:0] HIGH_LAST = CntWidth'(MaxHighCycles - 1);
    localparam logic [CntWidth-1:0] MIN_LEN   = CntWidth'(MinHighCycles);
    localparam logic [CntWidth-1:0] MAX_LEN   = CntWidth'(MaxHighCycles);
    localparam logic [CntWidth-1:0] THR_LEN   = CntWidth'(ThreshCycles);

    logic                sync_q;
    logic                s;
    logic                s_prev;
    logic                s_edge;
    logic                s_rise;
    logic                s_fall;
    logic [CntWidth-1:0] cnt;
    logic [CntWidth-1:0] high_len;
    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [22:0]         shreg;
    logic [4:0]          bit_cnt;
    logic [CntWidth-1:0] frame_cnt;
    logic                shift_en;
    logic                bit_val;
    logic                bit_clr;
    logic                word_done;
    logic                frame_end;
    logic                err_set;
    logic                accept;
    logic                ovf_set;

    assign s_edge   = s ^ s_prev;
    assign s_rise   = s & ~s_prev;
    assign s_fall   = ~s & s_prev;
    assign high_len = cnt + 1'b1;
    assign accept   = pixel_valid_o & pixel_ready_i;
    assign ovf_set  = word_done & pixel_valid_o & ~pixel_ready_i;

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= data_i;
            s      <= sync_q;
            s_prev <= s;
        end
    end

    // Level-duration counter: restarts on each edge, sticks at all-ones
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (s_edge) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Decoder next-state and per-cycle event decode
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        bit_val   = 1'b0;
        bit_clr   = 1'b0;
        word_done = 1'b0;
        frame_end = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_WAIT_GAP: begin
                if (!s && !s_edge && cnt >= GAP_LAST) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (s_rise) state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (s_fall) begin
                    if (high_len >= MIN_LEN && high_len <= MAX_LEN) begin
                        shift_en  = 1'b1;
                        bit_val   = (high_len >= THR_LEN);
                        word_done = (bit_cnt == 5'd23);
                        state_nxt = ST_LOW;
                    end else begin
                        err_set   = 1'b1;
                        bit_clr   = 1'b1;
                        state_nxt = ST_WAIT_GAP;
                    end
                end else if (cnt >= HIGH_LAST) begin
                    // still high past the longest legal pulse
                    err_set   = 1'b1;
                    bit_clr   = 1'b1;
                    state_nxt = ST_WAIT_GAP;
                end
            end
            ST_LOW: begin
                if (s_rise) begin
                    state_nxt = ST_HIGH;
                end else if (cnt >= GAP_LAST) begin
                    frame_end = 1'b1;
                    state_nxt = ST_IDLE;
                    if (bit_cnt != 5'd0) begin
                        err_set = 1'b1;
                        bit_clr = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_WAIT_GAP;
        endcase
    end

    // Decoder state register
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_WAIT_GAP;
        else        state <= state_nxt;
    end

    // MSB-first shift register and bit position within the current pixel
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (bit_clr) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= {shreg[21:0], bit_val};
            bit_cnt <= word_done ? 5'd0 : bit_cnt + 5'd1;
        end
    end

    // Output word register with valid/ready handshake; a word arriving
    // while the previous one is still pending and not taken is dropped
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_o       <= '0;
            pixel_valid_o <= 1'b0;
        end else if (word_done && (!pixel_valid_o || accept)) begin
            pixel_o       <= {shreg, bit_val};
            pixel_valid_o <= 1'b1;
        end else if (accept) begin
            pixel_valid_o <= 1'b0;
        end
    end

    // Per-frame pixel count, snapshot and done pulse at the latch gap
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt      <= '0;
            frame_pixels_o <= '0;
            frame_done_o   <= 1'b0;
        end else begin
            frame_done_o <= frame_end;
            if (frame_end) begin
                frame_pixels_o <= frame_cnt;
                frame_cnt      <= '0;
            end else if (word_done && frame_cnt != '1) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Sticky error and overflow flags; a set in the clear cycle wins
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o      <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (err_set)          err_o <= 1'b1;
            else if (err_clear_i) err_o <= 1'b0;
            if (ovf_set)          overflow_o <= 1'b1;
            else if (err_clear_i) overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_neopixel_rx.sv
// Directed bench for neopixel_rx: table of single-pixel frames with
// hand-computed decode results, plus sequences for the corner cases.
module tb_neopixel_rx;

    logic        soc_clk = 1'b0;
    logic        rst_n;
    logic        data_i;
    logic [23:0] pixel_o;
    logic        pixel_valid_o;
    logic        pixel_ready_i;
    logic        frame_done_o;
    logic [15:0] frame_pixels_o;
    logic        err_o;
    logic        overflow_o;
    logic        err_clear_i;

    neopixel_rx dut (
        .soc_clk        (soc_clk),
        .rst_n          (rst_n),
        .data_i         (data_i),
        .pixel_o        (pixel_o),
        .pixel_valid_o  (pixel_valid_o),
        .pixel_ready_i  (pixel_ready_i),
        .frame_done_o   (frame_done_o),
        .frame_pixels_o (frame_pixels_o),
        .err_o          (err_o),
        .overflow_o     (overflow_o),
        .err_clear_i    (err_clear_i)
    );

    always #5 soc_clk = ~soc_clk;

    int n_pass  = 0;
    int n_total = 0;

    // Output monitor, sampled on the falling edge
    int          px_count  = 0;
    int          fd_count  = 0;
    int          vlen      = 0;
    int          last_vlen = 0;
    logic [23:0] last_px   = '0;
    logic        prev_v    = 1'b0;

    always @(negedge soc_clk) begin
        if (pixel_valid_o && !prev_v) begin
            px_count = px_count + 1;
            last_px  = pixel_o;
        end
        if (pixel_valid_o) begin
            vlen = vlen + 1;
        end else begin
            if (prev_v) last_vlen = vlen;
            vlen = 0;
        end
        if (frame_done_o) fd_count = fd_count + 1;
        prev_v = pixel_valid_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send_bit(input int hi, input int lo);
        data_i = 1'b1;
        repeat (hi) @(negedge soc_clk);
        data_i = 1'b0;
        repeat (lo) @(negedge soc_clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int first, input int last,
                             input int hi1, input int lo1, input int hi0, input int lo0);
        for (int b = first; b >= last; b--) begin
            if (w[b]) send_bit(hi1, lo1);
            else      send_bit(hi0, lo0);
        end
    endtask

    task automatic gap(input int n);
        data_i = 1'b0;
        repeat (n) @(negedge soc_clk);
    endtask

    task automatic pulse_clear();
        err_clear_i = 1'b1;
        @(negedge soc_clk);
        err_clear_i = 1'b0;
        @(negedge soc_clk);
    endtask

    typedef struct {
        logic [23:0] word;
        int          hi1;
        int          lo1;
        int          hi0;
        int          lo0;
        logic [23:0] exp_px;
    } vec_t;

    vec_t vecs[5];

    int px0;
    int fd0;

    initial begin
        vecs[0] = '{word: 24'hA5C3F0, hi1: 16, lo1: 9, hi0: 8,  lo0: 17, exp_px: 24'hA5C3F0};
        vecs[1] = '{word: 24'h0F0F0F, hi1: 12, lo1: 9, hi0: 11, lo0: 17, exp_px: 24'h0F0F0F};
        vecs[2] = '{word: 24'hFFFFFF, hi1: 11, lo1: 9, hi0: 8,  lo0: 17, exp_px: 24'h000000};
        vecs[3] = '{word: 24'h000000, hi1: 16, lo1: 9, hi0: 12, lo0: 17, exp_px: 24'hFFFFFF};
        vecs[4] = '{word: 24'h5A5A5A, hi1: 40, lo1: 9, hi0: 3,  lo0: 17, exp_px: 24'h5A5A5A};

        rst_n         = 1'b0;
        data_i        = 1'b0;
        pixel_ready_i = 1'b1;
        err_clear_i   = 1'b0;
        repeat (3) @(negedge soc_clk);
        check("rst_pixel",    pixel_o,        0);
        check("rst_valid",    pixel_valid_o,  0);
        check("rst_done",     frame_done_o,   0);
        check("rst_fpix",     frame_pixels_o, 0);
        check("rst_err",      err_o,          0);
        check("rst_overflow", overflow_o,     0);
        rst_n = 1'b1;

        // Stream starts without a preceding gap: must not lock on
        gap(10);
        send_bits(24'hA5C3F0, 23, 0, 16, 9, 8, 17);
        gap(1020);
        check("nogap_pixels", px_count, 0);
        check("nogap_done",   fd_count, 0);
        check("nogap_err",    err_o,    0);

        // Single-pixel frames with ready held high
        for (int i = 0; i < 5; i++) begin
            px0 = px_count;
            fd0 = fd_count;
            send_bits(vecs[i].word, 23, 0, vecs[i].hi1, vecs[i].lo1, vecs[i].hi0, vecs[i].lo0);
            gap(1020);
            check($sformatf("v%0d_count", i), px_count - px0,  1);
            check($sformatf("v%0d_pixel", i), last_px,         vecs[i].exp_px);
            check($sformatf("v%0d_vlen", i),  last_vlen,       1);
            check($sformatf("v%0d_done", i),  fd_count - fd0,  1);
            check($sformatf("v%0d_fpix", i),  frame_pixels_o,  1);
            check($sformatf("v%0d_err", i),   err_o,           0);
        end

        // Three pixels with nobody accepting: first one held, rest dropped
        pixel_ready_i = 1'b0;
        px0 = px_count;
        fd0 = fd_count;
        send_bits(24'h000001, 23, 0, 16, 9, 8, 17);
        send_bits(24'hFFFFFF, 23, 0, 16, 9, 8, 17);
        send_bits(24'h123456, 23, 0, 16, 9, 8, 17);
        gap(1020);
        check("ovf_pixel",    pixel_o,        24'h000001);
        check("ovf_valid",    pixel_valid_o,  1);
        check("ovf_count",    px_count - px0, 1);
        check("ovf_flag",     overflow_o,     1);
        check("ovf_fpix",     frame_pixels_o, 3);
        check("ovf_done",     fd_count - fd0, 1);
        check("ovf_err",      err_o,          0);
        pixel_ready_i = 1'b1;
        @(negedge soc_clk);
        check("ovf_drop",     pixel_valid_o,  0);
        pulse_clear();
        check("ovf_cleared",  overflow_o,     0);

        // Too-short high pulse
        px0 = px_count;
        fd0 = fd_count;
        send_bit(2, 1020);
        check("glitch_err",   err_o,          1);
        check("glitch_count", px_count - px0, 0);
        check("glitch_done",  fd_count - fd0, 0);
        pulse_clear();
        check("glitch_clear", err_o,          0);

        // Too-long high pulse
        send_bit(50, 1020);
        check("long_err",     err_o,          1);
        check("long_count",   px_count - px0, 0);
        pulse_clear();
        check("long_clear",   err_o,          0);

        // Partial pixel at frame end
        fd0 = fd_count;
        send_bits(24'hABC000, 23, 12, 16, 9, 8, 17);
        gap(1020);
        check("part_done",    fd_count - fd0, 1);
        check("part_fpix",    frame_pixels_o, 0);
        check("part_err",     err_o,          1);
        check("part_count",   px_count - px0, 0);

        // Reset in the middle of bit 10 of a pixel
        send_bits(24'h123456, 23, 15, 16, 9, 8, 17);
        data_i = 1'b1;
        repeat (5) @(negedge soc_clk);
        rst_n = 1'b0;
        @(negedge soc_clk);
        check("mrst_pixel",    pixel_o,        0);
        check("mrst_valid",    pixel_valid_o,  0);
        check("mrst_done",     frame_done_o,   0);
        check("mrst_err",      err_o,          0);
        check("mrst_fpix",     frame_pixels_o, 0);
        check("mrst_overflow", overflow_o,     0);
        repeat (2) @(negedge soc_clk);
        rst_n = 1'b1;
        repeat (6) @(negedge soc_clk);
        data_i = 1'b0;
        repeat (9) @(negedge soc_clk);
        px0 = px_count;
        fd0 = fd_count;
        send_bits(24'h123456, 13, 0, 16, 9, 8, 17);
        send_bits(24'h654321, 23, 0, 16, 9, 8, 17);
        gap(1020);
        check("mrst_nolock_count", px_count - px0, 0);
        check("mrst_nolock_done",  fd_count - fd0, 0);
        check("mrst_nolock_err",   err_o,          0);
        send_bits(24'hC0FFEE, 23, 0, 16, 9, 8, 17);
        gap(1020);
        check("mrst_next_count", px_count - px0, 1);
        check("mrst_next_pixel", last_px,        24'hC0FFEE);
        check("mrst_next_done",  fd_count - fd0, 1);
        check("mrst_next_fpix",  frame_pixels_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
